// File: rtl/gpio_bank.sv
// gpio_bank: CHANNELS independent WIDTH-bit GPIO input/output channel pairs
// that sit on a shared data bus and are driven by control-unit strobes.
//
// Input path: each channel's input is synchronised through SYNC_STAGES flops.
// A change against the previous sample is captured in a per-channel latch.
// The change also raises a pending flag. A second change before the channel
// is read raises an overrun flag. After reset the block spends a short prime
// phase seeding the previous sample and latch from the synchroniser output,
// so static inputs present at reset never look like a change.
// Output path: a write loads one channel's output register and produces a
// one-cycle strobe for that channel.
//
// Ports:
//   clk      system clock, rising-edge active
//   reset    asynchronous active-low reset
//   sel      channel select for c_gi / c_go
//   c_gi     read latch[sel] onto dout, clear that channel's flags
//   c_gs     read status word {overrun, pending} onto dout
//   c_go     write din into output register of channel sel
//   din      data from bus
//   dout     data to bus (combinational from registers)
//   dout_oe  bus drive enable (c_gi | c_gs)
//   iport    external inputs, channel k at [k*WIDTH +: WIDTH]
//   oport    registered outputs, same packing
//   ostb     one-cycle write strobe per channel
//   irq      registered OR of all pending flags
module gpio_bank #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int SELW        = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SELW-1:0]              sel,
  input  logic                         c_gi,
  input  logic                         c_gs,
  input  logic                         c_go,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_oe,
  input  logic [CHANNELS*WIDTH-1:0]    iport,
  output logic [CHANNELS*WIDTH-1:0]    oport,
  output logic [CHANNELS-1:0]          ostb,
  output logic                         irq
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic {PRIME, ARMED} state_t;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic                        prime_done;
  logic                        armed;

  logic [CHANNELS*WIDTH-1:0]   sync_p [SYNC_STAGES];
  logic [CHANNELS*WIDTH-1:0]   s_p;
  logic [WIDTH-1:0]            prev  [CHANNELS];
  logic [WIDTH-1:0]            latch [CHANNELS];
  logic [CHANNELS-1:0]         pending;
  logic [CHANNELS-1:0]         overrun;

  logic [CHANNELS-1:0]         sel_hit;
  logic [CHANNELS-1:0]         chg;
  logic [CHANNELS-1:0]         clr;
  logic [WIDTH-1:0]            rd_latch;
  logic [WIDTH-1:0]            status;

  // Prime counter runs until the synchroniser has been filled with post-reset
  // samples, then the block arms change detection for good.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= PRIME;
      cnt   <= '0;
    end else begin
      case (state)
        PRIME: begin
          if (cnt == CNT_W'(SYNC_STAGES)) state <= ARMED;
          else                             cnt   <= cnt + CNT_W'(1);
        end
        ARMED:   state <= ARMED;
        default: state <= PRIME;
      endcase
    end
  end

  assign prime_done = (state == PRIME) && (cnt == CNT_W'(SYNC_STAGES));
  assign armed      = (state == ARMED);

  assign s_p = sync_p[SYNC_STAGES-1];

  // An out-of-range sel matches no channel, so reads return 0 and writes
  // and clears are dropped without any extra range logic.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      sel_hit[k] = (sel == SELW'(k));
      chg[k]     = (s_p[k*WIDTH +: WIDTH] != prev[k]);
      clr[k]     = c_gi & ~c_gs & sel_hit[k];
    end
  end

  always_comb begin
    rd_latch = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_hit[k]) rd_latch = latch[k];
    end
  end

  always_comb begin
    status = '0;
    status[CHANNELS-1:0]          = pending;
    status[2*CHANNELS-1:CHANNELS] = overrun;
  end

  always_comb begin
    if (c_gs)      dout = status;
    else if (c_gi) dout = rd_latch;
    else           dout = '0;
  end

  assign dout_oe = c_gi | c_gs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        prev[k]  <= '0;
        latch[k] <= '0;
      end
      pending <= '0;
      overrun <= '0;
      oport   <= '0;
      ostb    <= '0;
      irq     <= 1'b0;
    end else begin
      // stage boundary: external input -> synchroniser chain
      sync_p[0] <= iport;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];

      // stage boundary: synchroniser output -> change detect / flags
      irq  <= |pending;
      ostb <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        if (c_go && sel_hit[k]) begin
          oport[k*WIDTH +: WIDTH] <= din;
          ostb[k]                 <= 1'b1;
        end

        if (prime_done) begin
          prev[k]  <= s_p[k*WIDTH +: WIDTH];
          latch[k] <= s_p[k*WIDTH +: WIDTH];
        end else if (armed && chg[k]) begin
          // A new change wins over a simultaneous read-clear for pending,
          // but the read still acknowledges (clears) any earlier overrun.
          prev[k]    <= s_p[k*WIDTH +: WIDTH];
          latch[k]   <= s_p[k*WIDTH +: WIDTH];
          pending[k] <= 1'b1;
          overrun[k] <= clr[k] ? 1'b0 : (overrun[k] | pending[k]);
        end else if (clr[k]) begin
          pending[k] <= 1'b0;
          overrun[k] <= 1'b0;
        end
      end
    end
  end

endmodule
